// File: rtl/layer_compositor_pkg.sv
// Shared constants for the sprite layer compositor and the VGA timing generator
// that feeds it. Optional collision logic is enabled by COMPOSITOR_COLLISION_EN.
package layer_compositor_pkg;

    localparam int RGB_W              = 24;
    localparam int COMPOSITOR_LATENCY = 2;

    localparam logic [RGB_W-1:0] DEFAULT_COLOR_KEY = 24'hFF00FF;
    localparam logic [RGB_W-1:0] DEFAULT_BG_COLOR  = 24'h000000;

    // Shared with the timing generator so both agree on which level is "in pulse".
    localparam bit DEFAULT_VSYNC_ACTIVE_LOW = 1'b1;

    function automatic logic sync_idle_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-rate bus between the sprite renderers / timing generator and the
// compositor outputs (COMPOSITOR_COLLISION_EN selects the collision outputs).
interface layer_compositor_if
    import layer_compositor_pkg::*;
#(
    parameter int N_LAYERS = 4
) ();

    // No valid/ready: one pixel per clock in, one pixel per clock out, and the
    // pipeline never stalls, so every signal is sampled on every clk edge.
    logic [N_LAYERS-1:0]       layer_en;
    logic [RGB_W*N_LAYERS-1:0] layer_rgb;
    logic                      in_hsync;
    logic                      in_vsync;
    logic                      in_active;

    logic [7:0]                out_r;
    logic [7:0]                out_g;
    logic [7:0]                out_b;
    logic                      out_hsync;
    logic                      out_vsync;
    logic                      out_active;
    logic [N_LAYERS-1:0]       collision;
    logic                      collision_valid;
    logic [15:0]               frame_cnt;

    modport master (
        output layer_en, layer_rgb, in_hsync, in_vsync, in_active,
        input  out_r, out_g, out_b, out_hsync, out_vsync, out_active,
        input  collision, collision_valid, frame_cnt
    );

    modport slave (
        input  layer_en, layer_rgb, in_hsync, in_vsync, in_active,
        output out_r, out_g, out_b, out_hsync, out_vsync, out_active,
        output collision, collision_valid, frame_cnt
    );

endinterface

// File: rtl/layer_compositor_collision_tracker.sv
// Per-frame sprite overlap accumulator and frame counter; only instantiated
// when COMPOSITOR_COLLISION_EN is defined.
module layer_compositor_collision_tracker #(
    parameter int N_LAYERS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LAYERS-1:0] opaque,
    input  logic                frame_edge,
    output logic [N_LAYERS-1:0] collision,
    output logic                collision_valid,
    output logic [15:0]         frame_cnt
);

    localparam int CNT_W = $clog2(N_LAYERS + 1);

    logic [CNT_W-1:0]    pop;
    logic [N_LAYERS-1:0] hit;

    logic [N_LAYERS-1:0] acc_d, acc_q;
    logic [N_LAYERS-1:0] collision_d, collision_q;
    logic                valid_d, valid_q;
    logic [15:0]         frame_cnt_d, frame_cnt_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            pop = pop + CNT_W'(opaque[i]);
        end
        hit = (int'(pop) >= 2) ? opaque : '0;
    end

    // The edge cycle's own hits belong to the frame being closed.
    always_comb begin
        acc_d       = acc_q | hit;
        collision_d = collision_q;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (frame_edge) begin
            collision_d = acc_q | hit;
            acc_d       = '0;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            collision_q <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            collision_q <= collision_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign collision       = collision_q;
    assign collision_valid = valid_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: topmost opaque layer wins, background fallback,
// blanking, sync alignment. COMPOSITOR_COLLISION_EN adds per-frame overlap flags.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int               N_LAYERS         = 4,
    parameter logic [RGB_W-1:0] COLOR_KEY        = DEFAULT_COLOR_KEY,
    parameter logic [RGB_W-1:0] BG_COLOR         = DEFAULT_BG_COLOR,
    parameter bit               VSYNC_ACTIVE_LOW = DEFAULT_VSYNC_ACTIVE_LOW
) (
    input logic               clk,
    input logic               rst_n,
    layer_compositor_if.slave px
);

    localparam logic SYNC_IDLE = sync_idle_level(VSYNC_ACTIVE_LOW);

    logic [N_LAYERS-1:0]       opaque_d, opaque_q;
    logic [RGB_W*N_LAYERS-1:0] rgb1_d, rgb1_q;
    logic                      hs1_d, hs1_q;
    logic                      vs1_d, vs1_q;
    logic                      act1_d, act1_q;

    logic [RGB_W-1:0]          rgb2_d, rgb2_q;
    logic                      hs2_d, hs2_q;
    logic                      vs2_d, vs2_q;
    logic                      act2_d, act2_q;

    // Stage 1: opacity is gated by active so blanking can never produce a hit.
    always_comb begin
        opaque_d = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque_d[i] = px.layer_en[i]
                        & (px.layer_rgb[RGB_W*i +: RGB_W] != COLOR_KEY)
                        & px.in_active;
        end
        rgb1_d = px.layer_rgb;
        hs1_d  = px.in_hsync;
        vs1_d  = px.in_vsync;
        act1_d = px.in_active;
    end

    // Stage 2: walk from lowest priority up so the lowest opaque index wins.
    always_comb begin
        rgb2_d = BG_COLOR;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (opaque_q[i]) begin
                rgb2_d = rgb1_q[RGB_W*i +: RGB_W];
            end
        end
        if (!act1_q) begin
            rgb2_d = '0;
        end
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        act2_d = act1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opaque_q <= '0;
            rgb1_q   <= '0;
            hs1_q    <= SYNC_IDLE;
            vs1_q    <= SYNC_IDLE;
            act1_q   <= 1'b0;
            rgb2_q   <= '0;
            hs2_q    <= SYNC_IDLE;
            vs2_q    <= SYNC_IDLE;
            act2_q   <= 1'b0;
        end else begin
            opaque_q <= opaque_d;
            rgb1_q   <= rgb1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            act1_q   <= act1_d;
            rgb2_q   <= rgb2_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            act2_q   <= act2_d;
        end
    end

    assign px.out_r      = rgb2_q[23:16];
    assign px.out_g      = rgb2_q[15:8];
    assign px.out_b      = rgb2_q[7:0];
    assign px.out_hsync  = hs2_q;
    assign px.out_vsync  = vs2_q;
    assign px.out_active = act2_q;

`ifdef COMPOSITOR_COLLISION_EN
    // vs2_q is the previous stage-1 vsync, so it doubles as the edge history.
    logic frame_edge;
    assign frame_edge = (vs1_q != SYNC_IDLE) && (vs2_q == SYNC_IDLE);

    layer_compositor_collision_tracker #(
        .N_LAYERS (N_LAYERS)
    ) u_tracker (
        .clk             (clk),
        .rst_n           (rst_n),
        .opaque          (opaque_q),
        .frame_edge      (frame_edge),
        .collision       (px.collision),
        .collision_valid (px.collision_valid),
        .frame_cnt       (px.frame_cnt)
    );
`else
    assign px.collision       = '0;
    assign px.collision_valid = 1'b0;
    assign px.frame_cnt       = '0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: vector table for pixel selection plus
// hand-written frame sequences for collision flags, frame count, wrap and reset.
module tb_layer_compositor;
    import layer_compositor_pkg::*;

    localparam int N = 4;
    localparam int W = 31;   // {vs, hs, active, rgb[23:0], hit[3:0]}
`ifdef COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    layer_compositor_if #(.N_LAYERS(N)) bus ();

    layer_compositor #(.N_LAYERS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .px    (bus)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_valid  = 0;
    logic [3:0]   m_acc    = '0;
    logic [3:0]   m_coll   = '0;
    logic [15:0]  m_cnt    = '0;
    logic         m_valid  = 1'b0;
    logic         m_prev_vs = 1'b1;

    typedef struct {
        logic [3:0]  en;
        logic [95:0] rgb;
        logic        act;
        logic        hs;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [95:0] lay(input logic [23:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [3:0] hit_of(input logic [3:0] en, input logic [95:0] rgb,
                                          input logic act);
        logic [3:0] op;
        int         cnt;
        op  = '0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            op[i] = en[i] && act && (rgb[24*i +: 24] != 24'hFF00FF);
            if (op[i]) cnt++;
        end
        return (cnt >= 2) ? op : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc     = '0;
        m_coll    = '0;
        m_cnt     = '0;
        m_valid   = 1'b0;
        m_prev_vs = 1'b1;
    endtask

    // ---------------- driver ----------------
    // One call = one pixel clock; outputs seen now belong to the pixel driven two calls ago.
    task automatic pix(input logic [3:0] en, input logic [95:0] rgb, input logic act,
                       input logic hs, input logic vs, input logic [23:0] exp_rgb);
        logic [W-1:0] e;
        logic [3:0]   h;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("pix", 64'({bus.out_vsync, bus.out_hsync, bus.out_active,
                              bus.out_r, bus.out_g, bus.out_b}), 64'(e[30:4]));
            h = e[3:0];
            if (e[30] == 1'b0 && m_prev_vs == 1'b1) begin
                m_coll  = m_acc | h;
                m_acc   = '0;
                m_cnt   = m_cnt + 16'd1;
                m_valid = 1'b1;
            end else begin
                m_acc   = m_acc | h;
                m_valid = 1'b0;
            end
            m_prev_vs = e[30];
            check("coll", 64'({bus.collision, bus.collision_valid, bus.frame_cnt}),
                  COLL_EN ? 64'({m_coll, m_valid, m_cnt}) : 64'd0);
            if (bus.collision_valid) n_valid++;
        end
        bus.layer_en  = en;
        bus.layer_rgb = rgb;
        bus.in_active = act;
        bus.in_hsync  = hs;
        bus.in_vsync  = vs;
        exp_q.push_back({vs, hs, act, exp_rgb, hit_of(en, rgb, act)});
    endtask

    task automatic idle(input int n);
        repeat (n) pix(4'b0000, 96'd0, 1'b1, 1'b1, 1'b1, 24'h000000);
    endtask

    task automatic vs_pulse(input int n);
        repeat (n) pix(4'b0000, 96'd0, 1'b0, 1'b1, 1'b0, 24'h000000);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pix"}, 64'({bus.out_r, bus.out_g, bus.out_b, bus.out_active,
                                  bus.out_hsync, bus.out_vsync}), 64'({24'h0, 1'b0, 1'b1, 1'b1}));
        check({tag, "_coll"}, 64'({bus.collision, bus.collision_valid, bus.frame_cnt}), 64'd0);
    endtask

    // ---------------- test ----------------
    int          v0;
    logic [15:0] c0;

    initial begin
        tbl[0] = '{4'b0000, lay(24'h0, 24'h0, 24'h0, 24'h0),                         1'b1, 1'b1, 24'h000000};
        tbl[1] = '{4'b0110, lay(24'h0, 24'h123456, 24'hABCDEF, 24'h0),               1'b1, 1'b0, 24'h123456};
        tbl[2] = '{4'b0011, lay(24'hFF00FF, 24'h00FF00, 24'h0, 24'h0),               1'b1, 1'b0, 24'h00FF00};
        tbl[3] = '{4'b1111, lay(24'h111111, 24'h222222, 24'h333333, 24'h444444),     1'b0, 1'b1, 24'h000000};
        tbl[4] = '{4'b1111, lay(24'h111111, 24'h222222, 24'h333333, 24'h444444),     1'b1, 1'b1, 24'h111111};
        tbl[5] = '{4'b1000, lay(24'h111111, 24'h222222, 24'h333333, 24'h444444),     1'b1, 1'b0, 24'h444444};
        tbl[6] = '{4'b0100, lay(24'h111111, 24'h222222, 24'hFF00FF, 24'h444444),     1'b1, 1'b1, 24'h000000};
        tbl[7] = '{4'b1110, lay(24'h111111, 24'hFF00FE, 24'hABCDEF, 24'h444444),     1'b1, 1'b1, 24'hFF00FE};
        tbl[8] = '{4'b0001, lay(24'h0000FF, 24'h0, 24'h0, 24'h0),                    1'b0, 1'b0, 24'h000000};
        tbl[9] = '{4'b0000, lay(24'h0, 24'h0, 24'h0, 24'h0),                         1'b0, 1'b1, 24'h000000};

        bus.layer_en  = '0;
        bus.layer_rgb = '0;
        bus.in_active = 1'b1;
        bus.in_hsync  = 1'b1;
        bus.in_vsync  = 1'b1;

        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // idle with no layers: background after two cycles
        idle(4);

        for (int i = 0; i < 10; i++) begin
            pix(tbl[i].en, tbl[i].rgb, tbl[i].act, tbl[i].hs, 1'b1, tbl[i].exp_rgb);
        end
        idle(2);
        vs_pulse(2);
        idle(4);
        check("coll_table", 64'(bus.collision), COLL_EN ? 64'(4'b1111) : 64'd0);

        // layers 1 and 2 overlap
        idle(2);
        pix(4'b0110, lay(24'h0, 24'h123456, 24'hABCDEF, 24'h0), 1'b1, 1'b1, 1'b1, 24'h123456);
        idle(2);
        vs_pulse(2);
        idle(4);
        check("coll_overlap", 64'(bus.collision), COLL_EN ? 64'(4'b0110) : 64'd0);

        // keyed layer and single opaque layers never collide
        pix(4'b0011, lay(24'hFF00FF, 24'h00FF00, 24'h0, 24'h0), 1'b1, 1'b1, 1'b1, 24'h00FF00);
        pix(4'b0100, lay(24'h0, 24'h0, 24'h555555, 24'h0), 1'b1, 1'b1, 1'b1, 24'h555555);
        idle(2);
        vs_pulse(2);
        idle(4);
        check("coll_keyed", 64'(bus.collision), 64'd0);

        // everything enabled during blanking
        pix(4'b1111, lay(24'h111111, 24'h222222, 24'h333333, 24'h444444), 1'b0, 1'b1, 1'b1, 24'h000000);
        idle(2);
        vs_pulse(2);
        idle(4);
        check("coll_blank", 64'(bus.collision), 64'd0);

        // three long vsync pulses: one edge each
        v0 = n_valid;
        c0 = m_cnt;
        repeat (3) begin
            vs_pulse(8);
            idle(8);
        end
        check("valid_pulses", 64'(n_valid - v0), COLL_EN ? 64'd3 : 64'd0);
        check("frame_cnt3", 64'(bus.frame_cnt), COLL_EN ? 64'(c0 + 16'd3) : 64'd0);

`ifdef COMPOSITOR_COLLISION_EN
        force dut.u_tracker.frame_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        idle(1);
        release dut.u_tracker.frame_cnt_q;
        idle(2);
        vs_pulse(2);
        idle(4);
        check("cnt_ffff", 64'(bus.frame_cnt), 64'hFFFF);
        vs_pulse(2);
        idle(4);
        check("cnt_wrap", 64'(bus.frame_cnt), 64'h0000);
`endif

        // overlap, then reset mid-frame before the edge
        pix(4'b1100, lay(24'h0, 24'h0, 24'h333333, 24'h444444), 1'b1, 1'b1, 1'b1, 24'h333333);
        idle(2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3);
        vs_pulse(2);
        idle(4);
        check("coll_after_rst", 64'(bus.collision), 64'd0);
        check("cnt_after_rst", 64'(bus.frame_cnt), COLL_EN ? 64'd1 : 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Downstream of the per-sprite renderer instances; sits between them and the VGA output pins.
- Receives each sprite's enable and RGB, plus the raw timing signals (hsync, vsync, active) from the VGA timing generator.
- Selects the topmost opaque layer per pixel, falls back to a background colour, blanks outside the active area, and delays the syncs to stay aligned.
- Accumulates per-frame sprite-overlap (collision) flags for game logic.

Parameters:
- N_LAYERS, 4, number of sprite layers; index 0 is highest priority.
- COLOR_KEY, 24'hFF00FF, transparent colour; a layer pixel equal to this is not drawn.
- BG_COLOR, 24'h000000, colour shown where no layer is opaque.
- VSYNC_ACTIVE_LOW, 1, vsync polarity used for frame-edge detection.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- layer_en  in  N_LAYERS  per-layer enable from the renderers.
- layer_rgb  in  24*N_LAYERS  flattened {R,G,B}; layer i occupies bits [24*i+23 : 24*i].
- in_hsync  in  1  raw hsync.
- in_vsync  in  1  raw vsync.
- in_active  in  1  visible-area flag.
- out_r  out  8  composited red.
- out_g  out  8  composited green.
- out_b  out  8  composited blue.
- out_hsync  out  1  hsync delayed by 2 cycles.
- out_vsync  out  1  vsync delayed by 2 cycles.
- out_active  out  1  active flag delayed by 2 cycles.
- collision  out  N_LAYERS  bit i = layer i overlapped at least one other opaque layer in the last completed frame.
- collision_valid  out  1  1-cycle pulse when collision is updated.
- frame_cnt  out  16  completed-frame counter.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all pipeline registers cleared; out_r/g/b = 0; out_active = 0.
  - out_hsync/out_vsync = inactive level: 1 if active-low; hsync uses the same polarity as VSYNC_ACTIVE_LOW.
  - collision = 0, collision_valid = 0, frame_cnt = 0, accumulator = 0, vsync edge history = inactive.
- Latency is fixed at 2 cycles for RGB, syncs and active; there is no handshake and the pipeline always advances.
- Stage 1 (registered):
  - opaque[i] = layer_en[i] & (layer_rgb_i != COLOR_KEY) & in_active.
  - Register opaque, layer_rgb, hsync, vsync and active.
- Stage 2 (registered):
  - rgb = layer_rgb of the lowest index i with opaque[i].
  - If no layer is opaque, rgb = BG_COLOR.
  - If stage-1 active = 0, rgb = 0, overriding BG_COLOR.
- Collision detection:
  - In stage 2, hit[i] = opaque[i] & (popcount(opaque) >= 2).
  - accumulator |= hit every cycle.
- Frame edge = start of the vsync pulse, measured on the stage-1 vsync (transition inactive to active). On the edge, in the same cycle:
  - collision <= accumulator | hit for the current cycle.
  - accumulator <= 0.
  - collision_valid <= 1 for one cycle.
  - frame_cnt <= frame_cnt + 1, wrapping 16'hFFFF to 0.
- Boundary conditions:
  - Layer pixel exactly equal to COLOR_KEY with enable high is transparent and does not count as a hit.
  - Overlap while in_active = 0 is impossible, because opaque is gated by active.
  - A single opaque layer never sets its collision bit.
  - Vsync held active for many cycles produces exactly one edge.
  - Reset asserted mid-frame discards the accumulator; the first edge after reset reports only hits seen since reset.
- Widths: all comparisons are 24-bit; popcount width is clog2(N_LAYERS+1).

Optional Feature:
- COMPOSITOR_COLLISION_EN defined: collision accumulator, collision, collision_valid and frame_cnt behave as above.
- Undefined: that logic is not synthesised; collision = 0, collision_valid = 0, frame_cnt = 0 constantly. RGB and sync behaviour is identical in both builds.

Decomposition:
- Shared package/header holds:
  - RGB_W = 24.
  - COMPOSITOR_LATENCY = 2.
  - Default COLOR_KEY and BG_COLOR constants.
  - Sync polarity constant, shared with the VGA timing generator.
- Natural sub-module: collision_tracker. It takes the stage-2 opaque vector and the frame-edge strobe, and owns the accumulator, collision, collision_valid and frame_cnt. It is instantiated only under COMPOSITOR_COLLISION_EN.

Test Plan:
- Reset then idle with in_active = 1, no layer_en → after 2 cycles RGB = 000000 (BG_COLOR); syncs reflect inputs delayed exactly 2 cycles.
- layer_en = 4'b0110, layer1 = 123456, layer2 = ABCDEF → RGB = 123456 at cycle +2; next frame-edge collision = 4'b0110 with one valid pulse.
- layer_en = 4'b0011, layer0 = FF00FF, layer1 = 00FF00 → RGB = 00FF00; collision stays 0 at the next edge.
- in_active = 0 with layer_en = 4'b1111 and all layers opaque → RGB = 000000, no collision bits set.
- Three vsync pulses, each 2 lines long → frame_cnt = 3, exactly 3 collision_valid pulses; preload frame_cnt near FFFF to verify wrap to 0.
- Reset pulsed mid-frame after an overlap → outputs return to reset values asynchronously; the next edge reports collision = 0. Build without COMPOSITOR_COLLISION_EN → collision = 0 and frame_cnt = 0 throughout.
